// File: rtl/mem_pkg.sv
// Shared encodings, FSM state type and defaults for the data-memory load/store controller.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    localparam int unsigned DEPTH_WORDS_DEF = 128;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAPT,
        MERGE,
        WR,
        ERR,
        RESP
    } state_e;

    // True when the access cannot be served at this lane for this size.
    function automatic logic size_lane_bad(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = lane[0];
            SIZE_W:  bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends loads, merges sub-word stores into a word.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] mask;
    logic [31:0] ins;

    always_comb begin
        shamt   = {lane, 3'b000};
        shifted = rdata >> shamt;
        ld_byte = shifted[7:0];
        ld_half = shifted[15:0];

        case (size)
            SIZE_B:  ld_data = is_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SIZE_H:  ld_data = is_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_data = rdata;
        endcase
    end

    always_comb begin
        case (size)
            SIZE_B: begin
                mask = 32'h0000_00ff << shamt;
                ins  = {24'h0, wdata[7:0]} << shamt;
            end
            SIZE_H: begin
                mask = 32'h0000_ffff << shamt;
                ins  = {16'h0, wdata[15:0]} << shamt;
            end
            default: begin
                mask = 32'hffff_ffff;
                ins  = wdata;
            end
        endcase
        st_word = (rdata & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller for a word-wide data memory with 1-cycle registered reads.
// Sub-word stores are built as read-modify-write; all outputs are registered.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter logic [31:0] ADDR_BASE   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write,
    output logic [31:0] m_addr,
    output logic [31:0] m_w_data,
    input  logic [31:0] m_r_data
);

    state_e state_q, state_d;

    logic        accept;
    logic [31:0] off;
    logic [31:0] idx;
    logic        req_bad;

    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;

    logic        req_ready_q, req_ready_d;
    logic        mem_write_q, mem_write_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_w_data_q, m_w_data_d;

    logic [31:0] ld_data;
    logic [31:0] st_word;

    assign accept  = req_valid && req_ready_q;
    assign off     = req_addr - ADDR_BASE;
    assign idx     = {2'b00, off[31:2]};
    // Addresses below ADDR_BASE wrap to a huge index and fail the range check.
    assign req_bad = size_lane_bad(req_size, off[1:0]) || (idx >= DEPTH_WORDS);

    mem_lane_align u_lane_align (
        .rdata       (m_r_data),
        .wdata       (wdata_q),
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .ld_data     (ld_data),
        .st_word     (st_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_d = ERR;
                    end else if (req_write && (req_size == SIZE_W)) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = wr_q ? MERGE : CAPT;
            CAPT:    state_d = RESP;
            MERGE:   state_d = WR;
            WR:      state_d = RESP;
            ERR:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= 1'b0;
            size_q  <= SIZE_W;
            uns_q   <= 1'b0;
            lane_q  <= 2'b00;
            wdata_q <= '0;
        end else if (accept) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            lane_q  <= off[1:0];
            wdata_q <= req_wdata;
        end
    end

    // Outputs are decoded from the next state and registered alongside it.
    always_comb begin
        req_ready_d  = (state_d == IDLE);
        mem_write_d  = (state_d == WR);
        resp_valid_d = (state_d == RESP);
        resp_err_d   = (state_q == ERR) && (state_d == RESP);
        resp_rdata_d = resp_rdata_q;
        m_addr_d     = m_addr_q;
        m_w_data_d   = m_w_data_q;

        if (state_d == RESP) begin
            resp_rdata_d = (state_q == CAPT) ? ld_data : '0;
        end
        if ((state_q == IDLE) && ((state_d == RD) || (state_d == WR))) begin
            m_addr_d = idx;
        end
        if ((state_q == IDLE) && (state_d == WR)) begin
            m_w_data_d = req_wdata;
        end else if (state_q == MERGE) begin
            m_w_data_d = st_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_q  <= 1'b1;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            m_addr_q     <= '0;
            m_w_data_q   <= '0;
        end else begin
            req_ready_q  <= req_ready_d;
            mem_write_q  <= mem_write_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            m_addr_q     <= m_addr_d;
            m_w_data_q   <= m_w_data_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_write  = mem_write_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign m_addr     = m_addr_q;
    assign m_w_data   = m_w_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural word memory
// (falling-edge writes, 1-cycle registered reads).
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write;
    logic [31:0] m_addr;
    logic [31:0] m_w_data;
    logic [31:0] m_r_data;

    logic [31:0] mem [128];
    logic        pre_we;
    logic [6:0]  pre_addr;
    logic [31:0] pre_data;
    int          wr_total;
    logic [31:0] wr_addr;

    int checks;
    int errors;

    mem_access_ctrl #(
        .DEPTH_WORDS (128),
        .ADDR_BASE   (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_write    (mem_write),
        .m_addr       (m_addr),
        .m_w_data     (m_w_data),
        .m_r_data     (m_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) m_r_data <= mem[m_addr[6:0]];

    always @(negedge clk) begin
        if (mem_write) begin
            mem[m_addr[6:0]] <= m_w_data;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end
    end

    initial wr_total = 0;
    always @(negedge clk) begin
        if (mem_write) begin
            wr_total = wr_total + 1;
            wr_addr  = m_addr;
        end
    end

    task automatic preload(input logic [6:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    // Issues one request; lat counts edges from the accept edge (inclusive) to resp_valid.
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int nwr);
        int k;
        int w0;
        @(negedge clk);
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
        end
        w0           = wr_total;
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd  = resp_rdata;
        er  = resp_err;
        nwr = wr_total - w0;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b required 1", req_ready);
        end
        checks++;
        if ({resp_valid, resp_err, mem_write} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: valid/err/write=%b required 000",
                     {resp_valid, resp_err, mem_write});
        end
        checks++;
        if (resp_rdata !== 32'h0 || m_addr !== 32'h0 || m_w_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0",
                     resp_rdata, m_addr, m_w_data);
        end
    endtask

    task automatic test_word_rw();
        int lat; logic [31:0] rd; logic er; int nwr;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, nwr);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL wst_lat: got %0d required 2", lat); end
        checks++;
        if (nwr !== 1 || wr_addr !== 32'd4) begin
            errors++; $display("FAIL wst_write: count=%0d addr=%h required 1 @4", nwr, wr_addr);
        end
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL wst_resp: err=%b rdata=%h required 0/0", er, rd);
        end
        @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL wst_pulse: resp_valid=%b required 0", resp_valid);
        end
        checks++;
        if (mem[4] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wst_mem: got %h required deadbeef", mem[4]);
        end
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, nwr);
        checks++;
        if (lat !== 3 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL wld: lat=%0d rdata=%h err=%b required 3/deadbeef/0", lat, rd, er);
        end
    endtask

    task automatic test_byte_rmw();
        int lat; logic [31:0] rd; logic er; int nwr;
        preload(7'd4, 32'h11223344);
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h123456A5, lat, rd, er, nwr);
        checks++;
        if (lat !== 4 || nwr !== 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL bst: lat=%0d writes=%0d err=%b required 4/1/0", lat, nwr, er);
        end
        checks++;
        if (mem[4] !== 32'h1122A544) begin
            errors++; $display("FAIL bst_mem: got %h required 1122a544", mem[4]);
        end
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, rd, er, nwr);
        checks++;
        if (rd !== 32'hFFFFFFA5 || lat !== 3) begin
            errors++; $display("FAIL lb_signed: got %h lat %0d required ffffffa5/3", rd, lat);
        end
        issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, rd, er, nwr);
        checks++;
        if (rd !== 32'h000000A5) begin
            errors++; $display("FAIL lb_unsigned: got %h required 000000a5", rd);
        end
    endtask

    task automatic test_half();
        int lat; logic [31:0] rd; logic er; int nwr;
        preload(7'd4, 32'h80010000);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rd, er, nwr);
        checks++;
        if (rd !== 32'hFFFF8001) begin
            errors++; $display("FAIL lh_signed: got %h required ffff8001", rd);
        end
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rd, er, nwr);
        checks++;
        if (rd !== 32'h00008001) begin
            errors++; $display("FAIL lh_unsigned: got %h required 00008001", rd);
        end
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD7777, lat, rd, er, nwr);
        checks++;
        if (mem[4] !== 32'h77770000 || lat !== 4) begin
            errors++; $display("FAIL sh_mem: got %h lat %0d required 77770000/4", mem[4], lat);
        end
        // Highest in-range byte: index 127, lane 3.
        preload(7'd127, 32'hAB000000);
        issue(1'b0, 2'b00, 1'b1, 32'h1FF, 32'h0, lat, rd, er, nwr);
        checks++;
        if (rd !== 32'h000000AB || er !== 1'b0) begin
            errors++; $display("FAIL lb_top: got %h err %b required 000000ab/0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic        v_wr [4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  v_sz [4]   = '{2'b10, 2'b01, 2'b11, 2'b00};
        logic [31:0] v_ad [4]   = '{32'h02, 32'h03, 32'h00, 32'h200};
        int lat; logic [31:0] rd; logic er; int nwr;
        for (int i = 0; i < 4; i++) begin
            issue(v_wr[i], v_sz[i], 1'b0, v_ad[i], 32'hFFFFFFFF, lat, rd, er, nwr);
            checks++;
            if (er !== 1'b1 || lat !== 2 || nwr !== 0 || rd !== 32'h0) begin
                errors++;
                $display("FAIL err_%0d: err=%b lat=%0d writes=%0d rdata=%h required 1/2/0/0",
                         i, er, lat, nwr, rd);
            end
        end
    endtask

    task automatic test_reset_abort();
        int w0;
        int seen;
        preload(7'd8, 32'h01020304);
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            w0           = wr_total;
            req_valid    = 1'b1;
            req_write    = 1'b1;
            req_size     = (t == 0) ? 2'b10 : 2'b00;
            req_unsigned = 1'b0;
            req_addr     = (t == 0) ? 32'h20 : 32'h21;
            req_wdata    = 32'h55555555;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            if (t == 1) begin
                @(posedge clk);
                #1;
            end
            checks++;
            if (mem_write !== (t == 0)) begin
                errors++; $display("FAIL abort_pre_%0d: mem_write=%b", t, mem_write);
            end
            rst = 1'b1;
            #1;
            checks++;
            if (mem_write !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL abort_rst_%0d: mem_write=%b ready=%b required 0/1",
                         t, mem_write, req_ready);
            end
            @(negedge clk);
            #1;
            rst  = 1'b0;
            seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1;
                if (resp_valid) seen++;
            end
            checks++;
            if (seen !== 0 || mem[8] !== 32'h01020304 || wr_total !== w0) begin
                errors++;
                $display("FAIL abort_post_%0d: resp=%0d mem=%h writes=%0d required 0/01020304/0",
                         t, seen, mem[8], wr_total - w0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        logic [31:0] got [4];
        int acc_cyc [4];
        int n_acc, n_resp, dbl;
        logic rdy, prev_rv;
        for (int i = 0; i < 4; i++) preload(7'(10 + i), exp_d[i]);
        @(negedge clk);
        req_valid    = 1'b1;
        req_write    = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'd40;
        n_acc = 0; n_resp = 0; dbl = 0; prev_rv = 1'b0;
        for (int c = 0; c < 40 && n_resp < 4; c++) begin
            if (c != 0) @(negedge clk);
            rdy = req_ready;
            @(posedge clk);
            #1;
            if (rdy && req_valid) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                if (n_acc < 4) req_addr = 32'(40 + 4 * n_acc);
                else req_valid = 1'b0;
            end
            if (resp_valid) begin
                if (prev_rv) dbl++;
                got[n_resp] = resp_rdata;
                n_resp++;
            end
            prev_rv = resp_valid;
        end
        req_valid = 1'b0;
        checks++;
        if (n_resp !== 4 || n_acc !== 4 || dbl !== 0) begin
            errors++;
            $display("FAIL b2b_count: resp=%0d acc=%0d double=%0d required 4/4/0",
                     n_resp, n_acc, dbl);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== exp_d[i]) begin
                    errors++; $display("FAIL b2b_data_%0d: got %h required %h", i, got[i], exp_d[i]);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (acc_cyc[i] - acc_cyc[i-1] !== 4) begin
                    errors++;
                    $display("FAIL b2b_gap_%0d: got %0d required 4", i, acc_cyc[i] - acc_cyc[i-1]);
                end
            end
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        pre_we       = 1'b0;
        pre_addr     = '0;
        pre_data     = '0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_word_rw();
        test_byte_rmw();
        test_half();
        test_errors();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
